uart_word_assembler: RTL and testbench
======================================

Name: uart_word_assembler

Overview:
- Parametrised, multi-channel byte-to-word assembler between the UART receivers and the game logic.
- Each channel collects BYTES consecutive received bytes and concatenates them MSB-first into one word.
- Each completed word is announced with a one-cycle valid strobe.
- Uses an explicit byte counter, so zero-valued bytes are legal payload.
- A per-channel inter-byte timeout discards stale partial frames and flags an error.

Parameters:
- N_CH, 2, number of independent receive channels.
- BYTE_W, 8, width of one received byte.
- BYTES, 3, bytes per word (≥1); word width WORD_W = BYTES*BYTE_W.
- TMO_CYC, 1000000, clock cycles without a byte before a partial frame is dropped; 0 disables the timeout.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- rx_data  in  N_CH*BYTE_W  received bytes; channel c occupies bits [c*BYTE_W +: BYTE_W].
- rx_done_tick  in  N_CH  one-cycle strobe per channel: rx_data slice valid this cycle.
- word_out  out  N_CH*WORD_W  last completed word per channel, slice [c*WORD_W +: WORD_W]; held until the next completion.
- word_valid  out  N_CH  one-cycle pulse: word_out slice updated this cycle.
- timeout_err  out  N_CH  one-cycle pulse: a partial frame was discarded.
- busy  out  N_CH  high while a channel holds ≥1 byte of an incomplete frame.

Behaviour:
- Reset (rst_n low, asynchronous): all of the following clear to 0 immediately, regardless of clk:
  - word_out, word_valid, timeout_err, busy
  - byte counters, shift registers, timeout counters
- Reset release: the first frame starts from byte 0.
- Channels are fully independent, with no shared state; generate-loop per channel.
- Per-channel state machine, two states:
  - IDLE (cnt=0):
    - rx_done_tick → store byte, cnt=1, go COLLECT.
    - Exception: if BYTES=1, complete immediately and stay IDLE.
  - COLLECT (1 ≤ cnt ≤ BYTES-1):
    - rx_done_tick with cnt < BYTES-1 → shift in byte, cnt+1.
    - rx_done_tick with cnt = BYTES-1 → complete, cnt=0, go IDLE.
- Word ordering: the first received byte lands in word bits [WORD_W-1 -: BYTE_W]; the last byte in [BYTE_W-1:0].
- Completion latency:
  - If the final tick is sampled at edge N, word_out and word_valid=1 are visible after edge N.
  - word_valid drops after edge N+1.
  - Back-to-back completions on consecutive cycles give consecutive pulses; BYTES=1 with continuous ticks is legal.
- busy equals (state == COLLECT), registered.
- Timeout (only when TMO_CYC>0):
  - Timer clears on every tick and while IDLE; it increments each cycle in COLLECT.
  - When the timer reaches TMO_CYC-1 with no tick that cycle: discard the partial frame, cnt=0, go IDLE.
  - On that discard, pulse timeout_err for one cycle; word_out is unchanged and there is no word_valid.
- Simultaneous tick and timer expiry in the same cycle: the tick wins, the byte is accepted, the timer clears, and no error is raised.
- A tick arriving the cycle after a timeout starts a fresh frame as byte 0.
- Timer width is $clog2(TMO_CYC+1); the counter saturates and never wraps.
- Byte-counter width is $clog2(BYTES) (minimum 1 bit).
- rx_data bits are ignored when the channel's tick is low.
- Reset asserted mid-frame drops the partial frame with no error pulse.

Test Plan:
- Default params, ch0 ticks 0x12, 0x00, 0x34 (0x00 mid-frame) → after the 3rd tick word_out[23:0]=0x120034, word_valid[0] pulses exactly 1 cycle, busy[0] high between ticks then low.
- Both channels fed interleaved on identical cycles (ch0: AA BB CC, ch1: 01 02 03) → both word_valid bits pulse on the same cycle; ch0=0xAABBCC, ch1=0x010203; no crosstalk.
- TMO_CYC=16, ch0 gets 0x55 then no tick for 16 cycles → timeout_err[0] pulses once, busy[0] falls, word_out unchanged. Next bytes 0x11, 0x22, 0x33 → 0x112233.
- TMO_CYC=16, 2nd byte arrives exactly on the expiry cycle → no timeout_err; the frame completes normally with the 3rd byte.
- rst_n pulsed low asynchronously (between clock edges) after 2 bytes → outputs clear immediately. After release, 3 new bytes 0xDE, 0xAD, 0x01 give 0xDEAD01.
- BYTES=1, N_CH=1, ticks on 4 consecutive cycles with 0x01–0x04 → 4 consecutive word_valid pulses with word_out 0x01, 0x02, 0x03, 0x04.

Source files
------------

// File: rtl/uart_word_assembler.sv
// rtl/uart_word_assembler.sv - multi-channel byte-to-word assembler with inter-byte timeout
module uart_word_assembler #(
    parameter int N_CH    = 2,
    parameter int BYTE_W  = 8,
    parameter int BYTES   = 3,
    parameter int TMO_CYC = 1000000
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [N_CH*BYTE_W-1:0]   rx_data,
    input  logic [N_CH-1:0]          rx_done_tick,
    output logic [N_CH*BYTES*BYTE_W-1:0] word_out,
    output logic [N_CH-1:0]          word_valid,
    output logic [N_CH-1:0]          timeout_err,
    output logic [N_CH-1:0]          busy
);

    localparam int WORD_W = BYTES * BYTE_W;
    localparam int CNT_W  = (BYTES > 1) ? $clog2(BYTES) : 1;
    localparam int TMO_W  = (TMO_CYC > 0) ? $clog2(TMO_CYC + 1) : 1;
    localparam bit TMO_EN = (TMO_CYC > 0);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BYTES - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TMO_CYC > 0) ? (TMO_CYC - 1) : 0);

    typedef enum logic {
        S_IDLE    = 1'b0,
        S_COLLECT = 1'b1
    } state_t;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        state_t              state_q, state_d;
        logic [CNT_W-1:0]    cnt_q, cnt_d;
        logic [WORD_W-1:0]   sreg_q, sreg_d;
        logic [WORD_W-1:0]   word_q, word_d;
        logic [TMO_W-1:0]    tmr_q, tmr_d;
        logic                valid_q, valid_d;
        logic                terr_q, terr_d;
        logic [WORD_W-1:0]   byte_ext;
        logic [WORD_W-1:0]   shifted;
        logic                tick;
        logic                expire;

        assign tick = rx_done_tick[c];

        always_comb begin
            byte_ext = '0;
            byte_ext[BYTE_W-1:0] = rx_data[c*BYTE_W +: BYTE_W];
        end

        // After BYTES shifts every stale bit has left the register, so it never needs clearing.
        assign shifted = (sreg_q << BYTE_W) | byte_ext;
        assign expire  = TMO_EN && (state_q == S_COLLECT) && !tick && (tmr_q == TMO_LAST);

        always_comb begin
            state_d = state_q;
            cnt_d   = cnt_q;
            sreg_d  = sreg_q;
            word_d  = word_q;
            valid_d = 1'b0;
            terr_d  = 1'b0;
            tmr_d   = tmr_q;

            if (!TMO_EN || tick || state_q == S_IDLE) begin
                tmr_d = '0;
            end else if (tmr_q != '1) begin
                tmr_d = tmr_q + 1'b1;
            end

            if (tick) begin
                sreg_d = shifted;
                if (cnt_q == CNT_LAST) begin
                    word_d  = shifted;
                    valid_d = 1'b1;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
                    state_d = S_COLLECT;
                end
            end else if (expire) begin
                cnt_d   = '0;
                state_d = S_IDLE;
                terr_d  = 1'b1;
                tmr_d   = '0;
            end
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= S_IDLE;
                cnt_q   <= '0;
                sreg_q  <= '0;
                word_q  <= '0;
                tmr_q   <= '0;
                valid_q <= 1'b0;
                terr_q  <= 1'b0;
            end else begin
                state_q <= state_d;
                cnt_q   <= cnt_d;
                sreg_q  <= sreg_d;
                word_q  <= word_d;
                tmr_q   <= tmr_d;
                valid_q <= valid_d;
                terr_q  <= terr_d;
            end
        end

        assign word_out[c*WORD_W +: WORD_W] = word_q;
        assign word_valid[c]  = valid_q;
        assign timeout_err[c] = terr_q;
        assign busy[c]        = (state_q == S_COLLECT);
    end

endmodule

// File: tb/tb_uart_word_assembler.sv
// tb/tb_uart_word_assembler.sv - directed self-checking bench for uart_word_assembler
module tb_uart_word_assembler;

    logic        clk;
    logic        rst_n;

    logic [15:0] a_data;
    logic [1:0]  a_tick;
    logic [47:0] a_word;
    logic [1:0]  a_valid, a_terr, a_busy;

    logic [15:0] t_data;
    logic [1:0]  t_tick;
    logic [47:0] t_word;
    logic [1:0]  t_valid, t_terr, t_busy;

    logic [7:0]  b_data;
    logic [0:0]  b_tick;
    logic [7:0]  b_word;
    logic [0:0]  b_valid, b_terr, b_busy;

    int n_cmp = 0;
    int n_err = 0;

    uart_word_assembler dut_a (
        .clk(clk), .rst_n(rst_n), .rx_data(a_data), .rx_done_tick(a_tick),
        .word_out(a_word), .word_valid(a_valid), .timeout_err(a_terr), .busy(a_busy)
    );

    uart_word_assembler #(.TMO_CYC(16)) dut_t (
        .clk(clk), .rst_n(rst_n), .rx_data(t_data), .rx_done_tick(t_tick),
        .word_out(t_word), .word_valid(t_valid), .timeout_err(t_terr), .busy(t_busy)
    );

    uart_word_assembler #(.N_CH(1), .BYTES(1)) dut_b (
        .clk(clk), .rst_n(rst_n), .rx_data(b_data), .rx_done_tick(b_tick),
        .word_out(b_word), .word_valid(b_valid), .timeout_err(b_terr), .busy(b_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n  = 1'b0;
        a_data = '0; a_tick = '0;
        t_data = '0; t_tick = '0;
        b_data = '0; b_tick = '0;
        #12;
        chk("rst_a_word", a_word, 48'h0);
        chk("rst_a_flags", {a_valid, a_terr, a_busy}, 6'h0);
        chk("rst_b_word", b_word, 8'h0);
        rst_n = 1'b1;
        cyc();

        // Zero byte in the middle of a frame is still payload
        a_tick = 2'b01; a_data = 16'h0012; cyc();
        chk("s1_busy1", a_busy, 2'b01);
        chk("s1_valid1", a_valid, 2'b00);
        a_data = 16'h0000; cyc();
        chk("s1_busy2", a_busy, 2'b01);
        a_data = 16'h0034; cyc();
        chk("s1_word", a_word[23:0], 24'h120034);
        chk("s1_valid", a_valid, 2'b01);
        chk("s1_busy3", a_busy, 2'b00);
        a_tick = 2'b00; a_data = 16'hFFFF; cyc();
        chk("s1_valid_drop", a_valid, 2'b00);
        chk("s1_word_held", a_word, 48'h000000_120034);

        // Both channels on identical cycles
        a_tick = 2'b11; a_data = 16'h01AA; cyc();
        a_data = 16'h02BB; cyc();
        chk("s2_busy", a_busy, 2'b11);
        a_data = 16'h03CC; cyc();
        chk("s2_valid", a_valid, 2'b11);
        chk("s2_word", a_word, 48'h010203_AABBCC);
        a_tick = 2'b00; cyc();
        chk("s2_valid_drop", a_valid, 2'b00);

        // Second byte on the exact expiry cycle: tick wins
        t_tick = 2'b01; t_data = 16'h00A1; cyc();
        t_tick = 2'b00;
        repeat (15) cyc();
        chk("s4_busy_pre", t_busy, 2'b01);
        chk("s4_terr_pre", t_terr, 2'b00);
        t_tick = 2'b01; t_data = 16'h00A2; cyc();
        chk("s4_terr", t_terr, 2'b00);
        chk("s4_busy", t_busy, 2'b01);
        t_data = 16'h00A3; cyc();
        chk("s4_word", t_word[23:0], 24'hA1A2A3);
        chk("s4_valid", t_valid, 2'b01);
        t_tick = 2'b00; cyc();

        // Stale partial frame dropped after 16 idle cycles
        t_tick = 2'b01; t_data = 16'h0055; cyc();
        t_tick = 2'b00;
        repeat (15) cyc();
        chk("s3_busy_pre", t_busy, 2'b01);
        chk("s3_terr_pre", t_terr, 2'b00);
        cyc();
        chk("s3_terr", t_terr, 2'b01);
        chk("s3_busy", t_busy, 2'b00);
        chk("s3_word_unch", t_word[23:0], 24'hA1A2A3);
        chk("s3_novalid", t_valid, 2'b00);
        t_tick = 2'b01; t_data = 16'h0011; cyc();
        chk("s3_terr_once", t_terr, 2'b00);
        t_data = 16'h0022; cyc();
        t_data = 16'h0033; cyc();
        chk("s3_word_new", t_word[23:0], 24'h112233);
        chk("s3_valid_new", t_valid, 2'b01);
        t_tick = 2'b00; cyc();

        // Asynchronous reset mid-frame
        a_tick = 2'b01; a_data = 16'h0077; cyc();
        a_data = 16'h0088; cyc();
        a_tick = 2'b00;
        chk("s5_busy_pre", a_busy, 2'b01);
        #3 rst_n = 1'b0;
        #1;
        chk("s5_rst_word", a_word, 48'h0);
        chk("s5_rst_flags", {a_valid, a_terr, a_busy}, 6'h0);
        chk("s5_rst_t_word", t_word, 48'h0);
        #2 rst_n = 1'b1;
        a_tick = 2'b01; a_data = 16'h00DE; cyc();
        a_data = 16'h00AD; cyc();
        a_data = 16'h0001; cyc();
        chk("s5_word", a_word[23:0], 24'hDEAD01);
        chk("s5_valid", a_valid, 2'b01);
        chk("s5_terr", a_terr, 2'b00);
        a_tick = 2'b00; cyc();

        // BYTES=1 with continuous ticks
        b_tick = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            b_data = 8'(i);
            cyc();
            chk("s6_word", b_word, 8'(i));
            chk("s6_valid", b_valid, 1'b1);
            chk("s6_busy", b_busy, 1'b0);
        end
        b_tick = 1'b0; cyc();
        chk("s6_valid_drop", b_valid, 1'b0);
        chk("s6_word_held", b_word, 8'h04);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
